// File: rtl/rx_packet_parser_if.sv
// Receive word stream into the packet parser.
// Word moves on a rising clk edge where in_valid && in_ready; data and last are meaningful only while in_valid=1.
interface rx_packet_parser_if #(
    parameter int WORD_WIDTH = 16
);
    logic                  in_valid;
    logic                  in_ready;
    logic [WORD_WIDTH-1:0] in_data;
    logic                  in_last;

    modport master (
        output in_valid,
        output in_data,
        output in_last,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_last,
        output in_ready
    );
endinterface

// File: rtl/rx_packet_parser.sv
// Receive-side packet parser: decodes HB/NB packets and writes NB neighbour records
// into an external neighbour table, tracking the table fill count.
module rx_packet_parser #(
    parameter int WORD_WIDTH    = 16,
    parameter int MAX_NEIGHBORS = 32
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic [WORD_WIDTH-1:0] myNodeID,
    rx_packet_parser_if.slave     rx,
    output logic                  wr_en,
    output logic                  HB_reset,
    output logic [WORD_WIDTH-1:0] nodeID,
    output logic [WORD_WIDTH-1:0] nodeHops,
    output logic [WORD_WIDTH-1:0] nodeQValue,
    output logic [WORD_WIDTH-1:0] nodeEnergy,
    output logic [WORD_WIDTH-1:0] nodeCHHops,
    output logic [5:0]            neighborCount,
    output logic                  pkt_err,
    output logic                  tbl_full,
    output logic [1:0]            o_dbg_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        EMIT    = 2'd2,
        DROP    = 2'd3
    } state_t;

    localparam logic [3:0] TYPE_HB = 4'h1;
    localparam logic [3:0] TYPE_NB = 4'h2;
    localparam logic [5:0] MAX_CNT = 6'(MAX_NEIGHBORS);

    state_t                r_state;
    logic [2:0]            r_idx;
    logic                  r_in_ready;
    logic                  r_wr_en;
    logic                  r_hb_reset;
    logic                  r_pkt_err;
    logic [5:0]            r_count;
    logic                  r_tbl_full;
    logic [WORD_WIDTH-1:0] r_node_id;
    logic [WORD_WIDTH-1:0] r_node_hops;
    logic [WORD_WIDTH-1:0] r_node_qvalue;
    logic [WORD_WIDTH-1:0] r_node_energy;
    logic [WORD_WIDTH-1:0] r_node_chhops;

    state_t                w_nxt_state;
    logic [2:0]            w_nxt_idx;
    logic                  w_nxt_in_ready;
    logic                  w_nxt_wr_en;
    logic                  w_nxt_hb_reset;
    logic                  w_nxt_pkt_err;
    logic [5:0]            w_nxt_count;
    logic                  w_nxt_tbl_full;
    logic [WORD_WIDTH-1:0] w_nxt_node_id;
    logic [WORD_WIDTH-1:0] w_nxt_node_hops;
    logic [WORD_WIDTH-1:0] w_nxt_node_qvalue;
    logic [WORD_WIDTH-1:0] w_nxt_node_energy;
    logic [WORD_WIDTH-1:0] w_nxt_node_chhops;

    logic                  w_xfer;
    logic [3:0]            w_hdr_type;

    assign w_xfer     = rx.in_valid && r_in_ready;
    assign w_hdr_type = rx.in_data[15:12];

    always_comb begin
        w_nxt_state       = r_state;
        w_nxt_idx         = r_idx;
        w_nxt_wr_en       = 1'b0;
        w_nxt_hb_reset    = 1'b0;
        w_nxt_pkt_err     = 1'b0;
        w_nxt_count       = r_count;
        w_nxt_node_id     = r_node_id;
        w_nxt_node_hops   = r_node_hops;
        w_nxt_node_qvalue = r_node_qvalue;
        w_nxt_node_energy = r_node_energy;
        w_nxt_node_chhops = r_node_chhops;

        unique case (r_state)
            IDLE: begin
                if (w_xfer) begin
                    if (w_hdr_type == TYPE_HB) begin
                        if (rx.in_last) begin
                            w_nxt_hb_reset = 1'b1;
                            w_nxt_count    = 6'd0;
                        end else begin
                            w_nxt_pkt_err = 1'b1;
                            w_nxt_state   = DROP;
                        end
                    end else if (w_hdr_type == TYPE_NB && !rx.in_last) begin
                        w_nxt_state = COLLECT;
                        w_nxt_idx   = 3'd1;
                    end else begin
                        // Unknown type, or an NB header with no body.
                        w_nxt_pkt_err = 1'b1;
                        if (!rx.in_last) begin
                            w_nxt_state = DROP;
                        end
                    end
                end
            end

            COLLECT: begin
                if (w_xfer) begin
                    case (r_idx)
                        3'd1:    w_nxt_node_id     = rx.in_data;
                        3'd2:    w_nxt_node_hops   = rx.in_data;
                        3'd3:    w_nxt_node_qvalue = rx.in_data;
                        3'd4:    w_nxt_node_energy = rx.in_data;
                        3'd5:    w_nxt_node_chhops = rx.in_data;
                        default: ;
                    endcase

                    if (r_idx == 3'd5) begin
                        w_nxt_idx = 3'd0;
                        if (rx.in_last) begin
                            w_nxt_state = EMIT;
                            // Own echoes and a full table complete EMIT without writing.
                            w_nxt_wr_en = (r_node_id != myNodeID) && !r_tbl_full;
                        end else begin
                            w_nxt_pkt_err = 1'b1;
                            w_nxt_state   = DROP;
                        end
                    end else if (rx.in_last) begin
                        w_nxt_idx     = 3'd0;
                        w_nxt_pkt_err = 1'b1;
                        w_nxt_state   = IDLE;
                    end else begin
                        w_nxt_idx = r_idx + 3'd1;
                    end
                end
            end

            EMIT: begin
                // wr_en is only ever set below MAX_CNT, so this cannot overflow the table.
                if (r_wr_en) begin
                    w_nxt_count = r_count + 6'd1;
                end
                w_nxt_state = IDLE;
            end

            DROP: begin
                if (w_xfer && rx.in_last) begin
                    w_nxt_state = IDLE;
                end
            end

            default: begin
                w_nxt_state = IDLE;
                w_nxt_idx   = 3'd0;
            end
        endcase

        w_nxt_tbl_full = (w_nxt_count == MAX_CNT);
        w_nxt_in_ready = (w_nxt_state != EMIT);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state       <= IDLE;
            r_idx         <= 3'd0;
            r_in_ready    <= 1'b1;
            r_wr_en       <= 1'b0;
            r_hb_reset    <= 1'b0;
            r_pkt_err     <= 1'b0;
            r_count       <= 6'd0;
            r_tbl_full    <= 1'b0;
            r_node_id     <= '0;
            r_node_hops   <= '1;
            r_node_qvalue <= '0;
            r_node_energy <= '0;
            r_node_chhops <= '1;
        end else begin
            r_state       <= w_nxt_state;
            r_idx         <= w_nxt_idx;
            r_in_ready    <= w_nxt_in_ready;
            r_wr_en       <= w_nxt_wr_en;
            r_hb_reset    <= w_nxt_hb_reset;
            r_pkt_err     <= w_nxt_pkt_err;
            r_count       <= w_nxt_count;
            r_tbl_full    <= w_nxt_tbl_full;
            r_node_id     <= w_nxt_node_id;
            r_node_hops   <= w_nxt_node_hops;
            r_node_qvalue <= w_nxt_node_qvalue;
            r_node_energy <= w_nxt_node_energy;
            r_node_chhops <= w_nxt_node_chhops;
        end
    end

    assign rx.in_ready    = r_in_ready;
    assign wr_en          = r_wr_en;
    assign HB_reset       = r_hb_reset;
    assign pkt_err        = r_pkt_err;
    assign neighborCount  = r_count;
    assign tbl_full       = r_tbl_full;
    assign nodeID         = r_node_id;
    assign nodeHops       = r_node_hops;
    assign nodeQValue     = r_node_qvalue;
    assign nodeEnergy     = r_node_energy;
    assign nodeCHHops     = r_node_chhops;
    assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_rx_packet_parser.sv
// Directed testbench for rx_packet_parser: NB writes, HB clear, own echo, malformed packets,
// stalls, mid-packet reset and table saturation.
module tb_rx_packet_parser;

    localparam int W     = 16;
    localparam int MAXN  = 32;
    localparam int REC_W = 6 + 5 * W;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_EMIT    = 2'd2;
    localparam logic [1:0] ST_DROP    = 2'd3;

    logic         clk = 1'b0;
    logic         nrst;
    logic [W-1:0] my_id;
    logic         wr_en, hb_reset, pkt_err, tbl_full;
    logic [W-1:0] node_id, node_hops, node_qvalue, node_energy, node_chhops;
    logic [5:0]   ncount;
    logic [1:0]   dbg_state;

    rx_packet_parser_if #(.WORD_WIDTH(W)) rx ();

    rx_packet_parser #(
        .WORD_WIDTH   (W),
        .MAX_NEIGHBORS(MAXN)
    ) dut (
        .clk          (clk),
        .nrst         (nrst),
        .myNodeID     (my_id),
        .rx           (rx),
        .wr_en        (wr_en),
        .HB_reset     (hb_reset),
        .nodeID       (node_id),
        .nodeHops     (node_hops),
        .nodeQValue   (node_qvalue),
        .nodeEnergy   (node_energy),
        .nodeCHHops   (node_chhops),
        .neighborCount(ncount),
        .pkt_err      (pkt_err),
        .tbl_full     (tbl_full),
        .o_dbg_state  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int wr_cnt   = 0;
    int hb_cnt   = 0;
    int err_cnt  = 0;

    logic [REC_W-1:0] exp_q[$];
    logic [REC_W-1:0] obs_q[$];

    // Pulse monitor; writes are captured with the address seen during wr_en.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            obs_q.push_back({ncount, node_id, node_hops, node_qvalue, node_energy, node_chhops});
            wr_cnt++;
        end
        if (hb_reset === 1'b1) hb_cnt++;
        if (pkt_err === 1'b1) err_cnt++;
    end

    function automatic logic [REC_W-1:0] rec(input logic [5:0] c, input logic [W-1:0] id,
                                             input logic [W-1:0] h, input logic [W-1:0] q,
                                             input logic [W-1:0] e, input logic [W-1:0] ch);
        return {c, id, h, q, e, ch};
    endfunction

    // ---------------- drivers ----------------
    task automatic send_word(input logic [W-1:0] d, input logic last);
        int guard;
        guard = 0;
        @(negedge clk);
        rx.in_valid = 1'b1;
        rx.in_data  = d;
        rx.in_last  = last;
        while (rx.in_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (rx.in_ready !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL ready_timeout: in_ready=%b required 1", rx.in_ready);
        end
        @(posedge clk);
        #1;
        rx.in_valid = 1'b0;
        rx.in_last  = 1'b0;
    endtask

    task automatic send_nb(input logic [W-1:0] id, input logic [W-1:0] h, input logic [W-1:0] q,
                           input logic [W-1:0] e, input logic [W-1:0] ch);
        send_word(16'h2000, 1'b0);
        send_word(id, 1'b0);
        send_word(h, 1'b0);
        send_word(q, 1'b0);
        send_word(e, 1'b0);
        send_word(ch, 1'b1);
    endtask

    task automatic settle();
        repeat (3) @(negedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        nrst        = 1'b0;
        rx.in_valid = 1'b0;
        rx.in_data  = '0;
        rx.in_last  = 1'b0;
        my_id       = 16'h0001;
        repeat (2) @(negedge clk);
        n_checks++; if (wr_en !== 1'b0)          begin n_fail++; $display("FAIL reset_wr_en: got %b want 0", wr_en); end
        n_checks++; if (hb_reset !== 1'b0)       begin n_fail++; $display("FAIL reset_hb: got %b want 0", hb_reset); end
        n_checks++; if (pkt_err !== 1'b0)        begin n_fail++; $display("FAIL reset_err: got %b want 0", pkt_err); end
        n_checks++; if (ncount !== 6'd0)         begin n_fail++; $display("FAIL reset_count: got %0d want 0", ncount); end
        n_checks++; if (tbl_full !== 1'b0)       begin n_fail++; $display("FAIL reset_full: got %b want 0", tbl_full); end
        n_checks++; if (node_id !== 16'h0000)    begin n_fail++; $display("FAIL reset_node_id: got %h want 0000", node_id); end
        n_checks++; if (node_hops !== 16'hFFFF)  begin n_fail++; $display("FAIL reset_hops: got %h want ffff", node_hops); end
        n_checks++; if (node_qvalue !== 16'h0000) begin n_fail++; $display("FAIL reset_qvalue: got %h want 0000", node_qvalue); end
        n_checks++; if (node_energy !== 16'h0000) begin n_fail++; $display("FAIL reset_energy: got %h want 0000", node_energy); end
        n_checks++; if (node_chhops !== 16'hFFFF) begin n_fail++; $display("FAIL reset_chhops: got %h want ffff", node_chhops); end
        n_checks++; if (rx.in_ready !== 1'b1)    begin n_fail++; $display("FAIL reset_ready: got %b want 1", rx.in_ready); end
        n_checks++; if (dbg_state !== ST_IDLE)   begin n_fail++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
        nrst = 1'b1;
        settle();
    endtask

    task automatic test_nb_basic();
        logic [REC_W-1:0] e, g;
        my_id = 16'h0001;
        send_word(16'h2000, 1'b0);
        send_word(16'h0005, 1'b0);
        send_word(16'h0002, 1'b0);
        send_word(16'h1234, 1'b0);
        send_word(16'h0F00, 1'b0);
        send_word(16'h0001, 1'b1);
        n_checks++; if (wr_en !== 1'b1)        begin n_fail++; $display("FAIL nb_wr_en: got %b want 1", wr_en); end
        n_checks++; if (ncount !== 6'd0)       begin n_fail++; $display("FAIL nb_addr: got %0d want 0", ncount); end
        n_checks++; if ({node_id, node_hops, node_qvalue, node_energy, node_chhops} !== {16'h0005, 16'h0002, 16'h1234, 16'h0F00, 16'h0001})
                        begin n_fail++; $display("FAIL nb_fields: got %h %h %h %h %h want 0005 0002 1234 0f00 0001", node_id, node_hops, node_qvalue, node_energy, node_chhops); end
        n_checks++; if (rx.in_ready !== 1'b0)  begin n_fail++; $display("FAIL nb_emit_ready: got %b want 0", rx.in_ready); end
        n_checks++; if (dbg_state !== ST_EMIT) begin n_fail++; $display("FAIL nb_emit_state: got %0d want 2", dbg_state); end
        exp_q.push_back(rec(6'd0, 16'h0005, 16'h0002, 16'h1234, 16'h0F00, 16'h0001));
        @(posedge clk);
        #1;
        n_checks++; if (wr_en !== 1'b0)        begin n_fail++; $display("FAIL nb_wr_one_cycle: got %b want 0", wr_en); end
        n_checks++; if (ncount !== 6'd1)       begin n_fail++; $display("FAIL nb_count_inc: got %0d want 1", ncount); end
        n_checks++; if (rx.in_ready !== 1'b1)  begin n_fail++; $display("FAIL nb_ready_back: got %b want 1", rx.in_ready); end
        settle();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) begin n_fail++; $display("FAIL nb_write: got none want %h", e); end
            else begin g = obs_q.pop_front(); if (g !== e) begin n_fail++; $display("FAIL nb_write: got %h want %h", g, e); end end
        end
        n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL nb_extra_writes: got %0d want 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_hb();
        logic [REC_W-1:0] e, g;
        int h0;
        send_nb(16'h0011, 16'h0001, 16'h0100, 16'h0200, 16'h0003);
        exp_q.push_back(rec(6'd1, 16'h0011, 16'h0001, 16'h0100, 16'h0200, 16'h0003));
        send_nb(16'h0012, 16'h0004, 16'h0101, 16'h0201, 16'h0002);
        exp_q.push_back(rec(6'd2, 16'h0012, 16'h0004, 16'h0101, 16'h0201, 16'h0002));
        settle();
        n_checks++; if (ncount !== 6'd3) begin n_fail++; $display("FAIL hb_pre_count: got %0d want 3", ncount); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) begin n_fail++; $display("FAIL hb_nb_write: got none want %h", e); end
            else begin g = obs_q.pop_front(); if (g !== e) begin n_fail++; $display("FAIL hb_nb_write: got %h want %h", g, e); end end
        end
        h0 = hb_cnt;
        send_word(16'h1ABC, 1'b1);
        n_checks++; if (hb_reset !== 1'b1)      begin n_fail++; $display("FAIL hb_pulse: got %b want 1", hb_reset); end
        n_checks++; if (ncount !== 6'd0)        begin n_fail++; $display("FAIL hb_clear: got %0d want 0", ncount); end
        n_checks++; if (dbg_state !== ST_IDLE)  begin n_fail++; $display("FAIL hb_state: got %0d want 0", dbg_state); end
        @(posedge clk);
        #1;
        n_checks++; if (hb_reset !== 1'b0)      begin n_fail++; $display("FAIL hb_one_cycle: got %b want 0", hb_reset); end
        settle();
        n_checks++; if (hb_cnt != h0 + 1)       begin n_fail++; $display("FAIL hb_count: got %0d want %0d", hb_cnt, h0 + 1); end
    endtask

    task automatic test_own_echo();
        int w0, e0;
        w0 = wr_cnt;
        e0 = err_cnt;
        my_id = 16'h0007;
        send_nb(16'h0007, 16'h0001, 16'h0002, 16'h0003, 16'h0004);
        settle();
        n_checks++; if (wr_cnt != w0)       begin n_fail++; $display("FAIL echo_no_write: got %0d want %0d", wr_cnt, w0); end
        n_checks++; if (err_cnt != e0)      begin n_fail++; $display("FAIL echo_no_err: got %0d want %0d", err_cnt, e0); end
        n_checks++; if (ncount !== 6'd0)    begin n_fail++; $display("FAIL echo_count: got %0d want 0", ncount); end
        n_checks++; if (node_id !== 16'h0007) begin n_fail++; $display("FAIL echo_hold_id: got %h want 0007", node_id); end
        my_id = 16'h0001;
    endtask

    task automatic test_short_pkt();
        logic [REC_W-1:0] e, g;
        int w0, e0;
        w0 = wr_cnt;
        e0 = err_cnt;
        send_word(16'h2000, 1'b0);
        send_word(16'h0021, 1'b0);
        send_word(16'h0003, 1'b1);
        n_checks++; if (pkt_err !== 1'b1)      begin n_fail++; $display("FAIL short_err: got %b want 1", pkt_err); end
        n_checks++; if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL short_state: got %0d want 0", dbg_state); end
        settle();
        n_checks++; if (err_cnt != e0 + 1)     begin n_fail++; $display("FAIL short_err_count: got %0d want %0d", err_cnt, e0 + 1); end
        n_checks++; if (wr_cnt != w0)          begin n_fail++; $display("FAIL short_no_write: got %0d want %0d", wr_cnt, w0); end
        send_nb(16'h0022, 16'h0001, 16'h0002, 16'h0003, 16'h0004);
        exp_q.push_back(rec(6'd0, 16'h0022, 16'h0001, 16'h0002, 16'h0003, 16'h0004));
        settle();
        n_checks++; if (ncount !== 6'd1)       begin n_fail++; $display("FAIL short_next_count: got %0d want 1", ncount); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) begin n_fail++; $display("FAIL short_next_write: got none want %h", e); end
            else begin g = obs_q.pop_front(); if (g !== e) begin n_fail++; $display("FAIL short_next_write: got %h want %h", g, e); end end
        end
    endtask

    task automatic test_drop();
        int w0, e0, h0;
        w0 = wr_cnt;
        e0 = err_cnt;
        h0 = hb_cnt;
        send_word(16'h3000, 1'b0);
        n_checks++; if (pkt_err !== 1'b1 || dbg_state !== ST_DROP) begin n_fail++; $display("FAIL unknown_type: got err=%b state=%0d want err=1 state=3", pkt_err, dbg_state); end
        send_word(16'h1000, 1'b1);
        n_checks++; if (hb_reset !== 1'b0 || dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL drop_end: got hb=%b state=%0d want hb=0 state=0", hb_reset, dbg_state); end
        send_word(16'h1000, 1'b0);
        n_checks++; if (pkt_err !== 1'b1 || dbg_state !== ST_DROP) begin n_fail++; $display("FAIL hb_no_last: got err=%b state=%0d want err=1 state=3", pkt_err, dbg_state); end
        send_word(16'h0000, 1'b1);
        send_word(16'h2000, 1'b1);
        n_checks++; if (pkt_err !== 1'b1 || dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL nb_hdr_last: got err=%b state=%0d want err=1 state=0", pkt_err, dbg_state); end
        send_word(16'h2000, 1'b0);
        for (int i = 0; i < 5; i++) send_word(16'h0050 + 16'(i), 1'b0);
        n_checks++; if (pkt_err !== 1'b1 || dbg_state !== ST_DROP) begin n_fail++; $display("FAIL nb_long: got err=%b state=%0d want err=1 state=3", pkt_err, dbg_state); end
        send_word(16'h0000, 1'b1);
        settle();
        n_checks++; if (err_cnt != e0 + 4)  begin n_fail++; $display("FAIL drop_err_count: got %0d want %0d", err_cnt, e0 + 4); end
        n_checks++; if (hb_cnt != h0)       begin n_fail++; $display("FAIL drop_no_hb: got %0d want %0d", hb_cnt, h0); end
        n_checks++; if (wr_cnt != w0)       begin n_fail++; $display("FAIL drop_no_write: got %0d want %0d", wr_cnt, w0); end
        n_checks++; if (ncount !== 6'd1)    begin n_fail++; $display("FAIL drop_count: got %0d want 1", ncount); end
    endtask

    task automatic test_stall();
        logic [REC_W-1:0] e, g;
        logic [W-1:0] words[6];
        words = '{16'h2FFF, 16'h0033, 16'h0005, 16'hBEEF, 16'h0777, 16'h0002};
        for (int i = 0; i < 6; i++) begin
            send_word(words[i], (i == 5));
            if (i < 5) begin
                repeat (4) @(negedge clk);
                n_checks++;
                if (dbg_state !== ST_COLLECT) begin n_fail++; $display("FAIL stall_state: got %0d want 1", dbg_state); end
            end
        end
        exp_q.push_back(rec(6'd1, 16'h0033, 16'h0005, 16'hBEEF, 16'h0777, 16'h0002));
        settle();
        n_checks++; if (ncount !== 6'd2) begin n_fail++; $display("FAIL stall_count: got %0d want 2", ncount); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) begin n_fail++; $display("FAIL stall_write: got none want %h", e); end
            else begin g = obs_q.pop_front(); if (g !== e) begin n_fail++; $display("FAIL stall_write: got %h want %h", g, e); end end
        end
    endtask

    task automatic test_reset_mid();
        logic [REC_W-1:0] e, g;
        int w0;
        send_word(16'h2000, 1'b0);
        send_word(16'h0031, 1'b0);
        send_word(16'h0032, 1'b0);
        @(negedge clk);
        nrst = 1'b0;
        #1;
        n_checks++; if (ncount !== 6'd0 || dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL midrst_state: got count=%0d state=%0d want 0 0", ncount, dbg_state); end
        n_checks++; if ({node_id, node_hops, node_chhops} !== {16'h0000, 16'hFFFF, 16'hFFFF})
                        begin n_fail++; $display("FAIL midrst_fields: got %h %h %h want 0000 ffff ffff", node_id, node_hops, node_chhops); end
        @(negedge clk);
        nrst = 1'b1;
        w0 = wr_cnt;
        send_nb(16'h0041, 16'h0003, 16'h0444, 16'h0555, 16'h0001);
        exp_q.push_back(rec(6'd0, 16'h0041, 16'h0003, 16'h0444, 16'h0555, 16'h0001));
        settle();
        n_checks++; if (wr_cnt != w0 + 1) begin n_fail++; $display("FAIL midrst_one_write: got %0d want %0d", wr_cnt, w0 + 1); end
        n_checks++; if (ncount !== 6'd1)  begin n_fail++; $display("FAIL midrst_count: got %0d want 1", ncount); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) begin n_fail++; $display("FAIL midrst_write: got none want %h", e); end
            else begin g = obs_q.pop_front(); if (g !== e) begin n_fail++; $display("FAIL midrst_write: got %h want %h", g, e); end end
        end
    endtask

    task automatic test_full();
        logic [REC_W-1:0] e, g;
        int w0;
        send_word(16'h1000, 1'b1);
        settle();
        n_checks++; if (ncount !== 6'd0) begin n_fail++; $display("FAIL full_pre_clear: got %0d want 0", ncount); end
        w0 = wr_cnt;
        for (int i = 0; i < MAXN + 1; i++) begin
            send_nb(16'h0100 + 16'(i), 16'(i), 16'h0A00 + 16'(i), 16'h0B00, 16'h0001);
            if (i < MAXN) exp_q.push_back(rec(6'(i), 16'h0100 + 16'(i), 16'(i), 16'h0A00 + 16'(i), 16'h0B00, 16'h0001));
            if (i == MAXN - 2) begin
                settle();
                n_checks++; if (tbl_full !== 1'b0 || ncount !== 6'd31) begin n_fail++; $display("FAIL full_31: got full=%b count=%0d want 0 31", tbl_full, ncount); end
            end
            if (i == MAXN - 1) begin
                settle();
                n_checks++; if (tbl_full !== 1'b1 || ncount !== 6'd32) begin n_fail++; $display("FAIL full_32: got full=%b count=%0d want 1 32", tbl_full, ncount); end
            end
        end
        settle();
        n_checks++; if (wr_cnt != w0 + MAXN) begin n_fail++; $display("FAIL full_writes: got %0d want %0d", wr_cnt - w0, MAXN); end
        n_checks++; if (ncount !== 6'd32 || tbl_full !== 1'b1) begin n_fail++; $display("FAIL full_saturate: got count=%0d full=%b want 32 1", ncount, tbl_full); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) begin n_fail++; $display("FAIL full_write: got none want %h", e); end
            else begin g = obs_q.pop_front(); if (g !== e) begin n_fail++; $display("FAIL full_write: got %h want %h", g, e); end end
        end
        n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL full_extra_writes: got %0d want 0", obs_q.size()); obs_q.delete(); end
        send_word(16'h1000, 1'b1);
        settle();
        n_checks++; if (ncount !== 6'd0 || tbl_full !== 1'b0) begin n_fail++; $display("FAIL full_hb_clear: got count=%0d full=%b want 0 0", ncount, tbl_full); end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        test_reset();
        test_nb_basic();
        test_hb();
        test_own_echo();
        test_short_pkt();
        test_drop();
        test_stall();
        test_reset_mid();
        test_full();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
